inst_fetch: RTL

Instruction fetch stage for the single-cycle RISC-V core: holds the program counter, fetches one 32-bit instruction at a time from a variable-latency instruction memory, and presents it stable on `inst` to the Controller and datapath until the core commits it. On commit it computes the next PC from the Controller's `PCSrc` and the extended immediate, then issues the next fetch. It sits directly upstream of the Controller.

---
 rtl/inst_fetch.sv | 114 +++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, fetches one word at a time from a
// variable-latency instruction memory and holds it on inst until the core
// commits it, then steps the PC (sequential or PC-relative) and refetches.
// A misaligned next-PC parks the stage in a sticky fault state until reset.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrc,
    input  logic [31:0] imm_ext,
    input  logic        commit,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fault,
    output logic [31:0] instret
);

    localparam logic PC_J_OFFSET = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StHold,
        StFault
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] instret_q, instret_d;
    logic [31:0] pc_next;

    assign pc_plus4  = pc_q + 32'd4;
    assign pc_next   = (PCSrc == PC_J_OFFSET) ? (pc_q + imm_ext) : pc_plus4;
    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign instret   = instret_q;
    // The captured word is only exposed while held; everywhere else a NOP.
    assign inst      = inst_valid ? inst_q : NOP_INST;

    // Next-state, datapath updates and state-decoded outputs.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        instret_d  = instret_q;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        fault      = 1'b0;
        case (state_q)
            StIdle: begin
                state_d = StReq;
            end
            StReq: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                // Only a response arriving here belongs to our request.
                if (imem_rvalid) begin
                    inst_d  = imem_rdata;
                    state_d = StHold;
                end
            end
            StHold: begin
                inst_valid = 1'b1;
                if (commit) begin
                    instret_d = instret_q + 32'd1;
                    if (pc_next[1:0] != 2'b00) begin
                        // Keep the PC of the instruction that produced the bad target.
                        state_d = StFault;
                    end else begin
                        pc_d    = pc_next;
                        state_d = StReq;
                    end
                end
            end
            StFault: begin
                fault = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register; reset wins over any same-cycle commit or response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            inst_q    <= NOP_INST;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            instret_q <= instret_d;
        end
    end

endmodule
